// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory behind a valid/ready request channel
// and a valid/ready response channel. One request is in flight at a time;
// WAIT_CYCLES wait states separate acceptance from the array access.
// Ports:
//   clk, proc_rst              clock, async active-low reset
//   req_valid/req_ready        request handshake
//   req_write/addr/wdata       request fields, held stable by requester
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata/write/err        response fields, stable while rsp_valid
//   access_cnt                 count of completed response handshakes
module mem_responder #(
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              proc_rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_write,
   output logic              rsp_err,
   output logic [15:0]       access_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t              state_q, state_d;
   logic [3:0]          wait_q, wait_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                write_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                req_ready_q, req_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_write_q, rsp_write_d;
   logic                rsp_err_q, rsp_err_d;
   logic [15:0]         access_cnt_q, access_cnt_d;

   logic                accept_s, access_s, rsp_hs_s, in_range_s, mem_we_s;
   logic [ADDR_W-1:0]   acc_addr_s;
   logic [DATA_W-1:0]   acc_wdata_s, rd_word_s;
   logic                acc_write_s;

   assign accept_s = req_valid & req_ready_q;
   assign rsp_hs_s = rsp_valid_q & rsp_ready;

   // With zero wait states the access happens on the acceptance edge, so the
   // live request fields are used in IDLE and the latched copy afterwards.
   assign acc_addr_s  = (state_q == ST_IDLE) ? req_addr  : addr_q;
   assign acc_wdata_s = (state_q == ST_IDLE) ? req_wdata : wdata_q;
   assign acc_write_s = (state_q == ST_IDLE) ? req_write : write_q;
   assign in_range_s  = ({1'b0, acc_addr_s} < DEPTH_C);
   assign mem_we_s    = access_s & acc_write_s & in_range_s;

   // Read mux over the implemented words; out-of-range addresses select none.
   always_comb begin
      rd_word_s = '0;
      for (int i = 0; i < DEPTH; i++) begin
         rd_word_s = rd_word_s | (mem_q[i] & {DATA_W{acc_addr_s == ADDR_W'(i)}});
      end
   end

   // State register and wait counter.
   always_ff @(posedge clk or negedge proc_rst) begin
      if (!proc_rst) begin
         state_q <= ST_IDLE;
         wait_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state logic; access_s marks the edge on which the array is touched.
   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      access_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               if (WAIT_CYCLES == 0) begin
                  access_s = 1'b1;
                  state_d  = ST_RESP;
               end else begin
                  wait_d  = WAIT_L;
                  state_d = ST_WAIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            wait_d = wait_q - 4'd1;
            // <= also recovers from a corrupted zero count
            if (wait_q <= 4'd1) begin
               wait_d   = 4'd0;
               access_s = 1'b1;
               state_d  = ST_RESP;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (rsp_hs_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
            wait_d  = 4'd0;
         end
      endcase
   end

   // Output next-values; all outputs come straight from flops.
   always_comb begin
      req_ready_d  = (state_d == ST_IDLE);
      rsp_valid_d  = (state_d == ST_RESP);
      rsp_rdata_d  = rsp_rdata_q;
      rsp_write_d  = rsp_write_q;
      rsp_err_d    = rsp_err_q;
      access_cnt_d = access_cnt_q;
      if (access_s) begin
         rsp_write_d = acc_write_s;
         rsp_err_d   = ~in_range_s;
         rsp_rdata_d = (in_range_s && !acc_write_s) ? rd_word_s : '0;
      end else if (rsp_hs_s) begin
         rsp_err_d    = 1'b0;
         access_cnt_d = access_cnt_q + 16'd1;
      end else begin
         access_cnt_d = access_cnt_q;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge proc_rst) begin
      if (!proc_rst) begin
         req_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_write_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         access_cnt_q <= 16'd0;
      end else begin
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_write_q  <= rsp_write_d;
         rsp_err_q    <= rsp_err_d;
         access_cnt_q <= access_cnt_d;
      end
   end

   // Request field capture on acceptance.
   always_ff @(posedge clk or negedge proc_rst) begin
      if (!proc_rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
      end else if (accept_s) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         write_q <= req_write;
      end
   end

   // Word array; reset clears every word, which also discards a pending write.
   always_ff @(posedge clk or negedge proc_rst) begin
      if (!proc_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (mem_we_s && (acc_addr_s == ADDR_W'(i))) begin
               mem_q[i] <= acc_wdata_s;
            end
         end
      end
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_write  = rsp_write_q;
   assign rsp_err    = rsp_err_q;
   assign access_cnt = access_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder. Instance 0 uses WAIT_CYCLES=2,
// DEPTH=64; instance 1 uses WAIT_CYCLES=0, DEPTH=48.
`timescale 1ns/1ps
module tb_mem_responder;
   localparam int AW = 6;
   localparam int DW = 16;

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          wr;
      logic          err;
   } exp_t;

   logic          clk = 1'b0;
   logic          proc_rst;
   logic          req_valid [2];
   logic          req_write [2];
   logic [AW-1:0] req_addr  [2];
   logic [DW-1:0] req_wdata [2];
   logic          req_ready [2];
   logic          rsp_valid [2];
   logic          rsp_ready [2];
   logic [DW-1:0] rsp_rdata [2];
   logic          rsp_write [2];
   logic          rsp_err   [2];
   logic [15:0]   access_cnt[2];

   int   checks   = 0;
   int   failures = 0;
   exp_t sb0[$];
   exp_t sb1[$];
   logic [DW-1:0] wv [4];

   always #5 clk = ~clk;

   mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(64), .WAIT_CYCLES(2)) u_dut_w2 (
      .clk(clk), .proc_rst(proc_rst),
      .req_valid(req_valid[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_write(rsp_write[0]), .rsp_err(rsp_err[0]), .access_cnt(access_cnt[0]));

   mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(48), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .proc_rst(proc_rst),
      .req_valid(req_valid[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_write(rsp_write[1]), .rsp_err(rsp_err[1]), .access_cnt(access_cnt[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_rsp(input int k, input exp_t e);
      chk($sformatf("rsp%0d_rdata", k), 32'(rsp_rdata[k]), 32'(e.rdata));
      chk($sformatf("rsp%0d_write", k), 32'(rsp_write[k]), 32'(e.wr));
      chk($sformatf("rsp%0d_err", k),   32'(rsp_err[k]),   32'(e.err));
   endtask

   // Monitors: pop and compare on every response handshake.
   always @(negedge clk) begin
      exp_t e;
      if (proc_rst === 1'b1 && rsp_valid[0] && rsp_ready[0]) begin
         if (sb0.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp0_unexpected: got response, expected none");
         end else begin
            e = sb0.pop_front();
            chk_rsp(0, e);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (proc_rst === 1'b1 && rsp_valid[1] && rsp_ready[1]) begin
         if (sb1.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp1_unexpected: got response, expected none");
         end else begin
            e = sb1.pop_front();
            chk_rsp(1, e);
         end
      end
   end

   // Issue one request, check latency, optionally hold off rsp_ready for
   // 'stall' cycles while checking stability, then complete the handshake.
   task automatic do_req(input int k, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd,
                         input logic exp_err, input int exp_lat, input int stall);
      int   n;
      int   lat;
      exp_t e;
      e.rdata = exp_rd; e.wr = wr; e.err = exp_err;
      if (k == 0) sb0.push_back(e); else sb1.push_back(e);
      rsp_ready[k] = (stall == 0);
      req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = a; req_wdata[k] = wd;
      n = 0;
      @(negedge clk);
      while (!req_ready[k] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_bound", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      lat = 0;
      while (!rsp_valid[k] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("rsp%0d_latency", k), 32'(lat), 32'(exp_lat));
      for (int i = 0; i < stall; i++) begin
         chk("bp_rsp_valid", 32'(rsp_valid[k]), 32'd1);
         chk("bp_rdata",     32'(rsp_rdata[k]), 32'(exp_rd));
         chk("bp_req_ready", 32'(req_ready[k]), 32'd0);
         if (i == 2) begin
            req_valid[k] = 1'b1; req_write[k] = 1'b1; req_addr[k] = a; req_wdata[k] = 16'hDEAD;
         end else begin
            req_valid[k] = 1'b0;
         end
         @(posedge clk); #1;
      end
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!(rsp_valid[k] && rsp_ready[k]) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("handshake_bound", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      wv[0] = 16'h1111; wv[1] = 16'h2222; wv[2] = 16'h3333; wv[3] = 16'h4444;
      proc_rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
         req_wdata[k] = '0;   rsp_ready[k] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_req_ready", 32'(req_ready[k]), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
         chk("rst_access_cnt", 32'(access_cnt[k]), 32'd0);
      end
      proc_rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("idle_req_ready", 32'(req_ready[k]), 32'd1);
         chk("idle_access_cnt", 32'(access_cnt[k]), 32'd0);
      end

      // Test 1/2/3 on the two-wait-state instance.
      do_req(0, 1'b0, 6'd5,    16'h0000, 16'h0000, 1'b0, 2, 0);
      do_req(0, 1'b1, 6'h0A,   16'hBEEF, 16'h0000, 1'b0, 2, 0);
      do_req(0, 1'b0, 6'h0A,   16'h0000, 16'hBEEF, 1'b0, 2, 0);
      chk("cnt0_after_rw", 32'(access_cnt[0]), 32'd3);
      do_req(0, 1'b1, 6'd3,    16'h1234, 16'h0000, 1'b0, 2, 0);
      do_req(0, 1'b0, 6'd3,    16'h0000, 16'h1234, 1'b0, 2, 5);
      do_req(0, 1'b0, 6'd3,    16'h0000, 16'h1234, 1'b0, 2, 0);
      chk("cnt0_after_bp", 32'(access_cnt[0]), 32'd6);

      // Test 4/5 on the zero-wait, 48-word instance.
      for (int i = 0; i < 4; i++) do_req(1, 1'b1, 6'(i), wv[i], 16'h0000, 1'b0, 0, 0);
      for (int i = 0; i < 4; i++) do_req(1, 1'b0, 6'(i), 16'h0000, wv[i], 1'b0, 0, 0);
      chk("cnt1_b2b", 32'(access_cnt[1]), 32'd8);
      do_req(1, 1'b1, 6'd50, 16'hFFFF, 16'h0000, 1'b1, 0, 0);
      do_req(1, 1'b0, 6'd50, 16'h0000, 16'h0000, 1'b1, 0, 0);
      do_req(1, 1'b1, 6'd63, 16'h5A5A, 16'h0000, 1'b1, 0, 0);
      for (int i = 0; i < 4; i++) do_req(1, 1'b0, 6'(i), 16'h0000, wv[i], 1'b0, 0, 0);
      do_req(1, 1'b0, 6'd47, 16'h0000, 16'h0000, 1'b0, 0, 0);
      do_req(1, 1'b0, 6'd18, 16'h0000, 16'h0000, 1'b0, 0, 0);
      chk("cnt1_after_err", 32'(access_cnt[1]), 32'd17);

      // Leave instance 1 holding a read response, then reset instance 0 in WAIT.
      rsp_ready[1] = 1'b0;
      req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 6'd1;
      @(negedge clk);
      chk("pend_req_ready", 32'(req_ready[1]), 32'd1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      chk("pend_rsp_valid", 32'(rsp_valid[1]), 32'd1);
      chk("pend_rdata", 32'(rsp_rdata[1]), 32'h2222);

      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 6'd7; req_wdata[0] = 16'hAAAA;
      @(negedge clk);
      chk("w7_req_ready", 32'(req_ready[0]), 32'd1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(posedge clk); #2;
      proc_rst = 1'b0;
      #1;
      chk("async_rsp_valid1", 32'(rsp_valid[1]), 32'd0);
      chk("async_rdata1",     32'(rsp_rdata[1]), 32'd0);
      chk("async_err1",       32'(rsp_err[1]),   32'd0);
      chk("async_cnt1",       32'(access_cnt[1]), 32'd0);
      chk("async_req_ready0", 32'(req_ready[0]), 32'd0);
      chk("async_cnt0",       32'(access_cnt[0]), 32'd0);
      @(posedge clk); #1;
      proc_rst = 1'b1;
      rsp_ready[1] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      do_req(0, 1'b0, 6'd7, 16'h0000, 16'h0000, 1'b0, 2, 0);
      chk("cnt0_after_wait_rst", 32'(access_cnt[0]), 32'd1);
      do_req(1, 1'b0, 6'd1, 16'h0000, 16'h0000, 1'b0, 0, 0);
      chk("cnt1_after_rst", 32'(access_cnt[1]), 32'd1);

      // Counter wrap: preload 65535, one more handshake returns it to 0.
      force u_dut_w0.access_cnt_d = 16'hFFFF;
      @(posedge clk); #1;
      release u_dut_w0.access_cnt_d;
      chk("cnt1_preload", 32'(access_cnt[1]), 32'h0000FFFF);
      do_req(1, 1'b0, 6'd0, 16'h0000, 16'h0000, 1'b0, 0, 0);
      chk("cnt1_wrap", 32'(access_cnt[1]), 32'd0);

      chk("sb0_drained", 32'(sb0.size()), 32'd0);
      chk("sb1_drained", 32'(sb1.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
